fetch_decode_stage: RTL

//  Parametrised successor to the single-cycle PC/PC+4/instruction-fetch front end.

---
 rtl/fetch_decode_stage_if.sv | 25 ++
 rtl/fetch_decode_stage.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_decode_stage_if.sv
// fetch_decode_stage_if: instruction-memory request/acknowledge bus.
// The master (fetch stage) raises imem_req with a stable imem_addr and holds it
// until the slave (instruction memory) answers with imem_ack and imem_rdata.
interface fetch_decode_stage_if #(
   parameter int unsigned XLEN = 32
);
   logic            imem_req;
   logic [XLEN-1:0] imem_addr;
   logic            imem_ack;
   logic [31:0]     imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ack,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ack,
      output imem_rdata
   );
endinterface

// File: rtl/fetch_decode_stage.sv
// fetch_decode_stage: owns the PC, issues one handshaked fetch at a time to an
// instruction memory of variable latency, and holds the result in an IF/ID
// register with valid/stall/flush/redirect handling. A one-entry skid buffer
// absorbs a response that lands while IF/ID is stalled. MIPS32 fields are
// pre-decoded and J is resolved locally when J_LOCAL is set.
// Optional macro FETCH_STATS_EN adds saturating fetch/stall/drop counters.
module fetch_decode_stage #(
   parameter int unsigned     XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}},
   parameter bit              J_LOCAL  = 1'b1
) (
   input  logic                 Clk,
   input  logic                 Rst,
   input  logic                 i_stall,
   input  logic                 i_flush,
   input  logic                 i_redirect,
   input  logic [XLEN-1:0]      i_redirect_pc,
   fetch_decode_stage_if.master imem,
   output logic                 o_valid,
   output logic [XLEN-1:0]      o_pc,
   output logic [XLEN-1:0]      o_pc4,
   output logic [31:0]          o_instr,
   output logic [4:0]           o_rs,
   output logic [4:0]           o_rt,
   output logic [4:0]           o_rd,
   output logic [XLEN-1:0]      o_imm
`ifdef FETCH_STATS_EN
   ,
   output logic [31:0]          o_fetch_cnt,
   output logic [31:0]          o_stall_cnt,
   output logic [31:0]          o_drop_cnt
`endif
);

   typedef enum logic [1:0] {
      ST_BOOT = 2'd0,
      ST_REQ  = 2'd1,
      ST_HOLD = 2'd2,
      ST_DROP = 2'd3
   } state_t;

   localparam logic [5:0]      OP_J       = 6'b000010;
   localparam logic [XLEN-1:0] PC_INC     = {{(XLEN-3){1'b0}}, 3'b100};
   localparam logic [XLEN-1:0] PC_MASK    = {{(XLEN-2){1'b1}}, 2'b00};
   localparam logic [XLEN-1:0] RESET_PC_A = RESET_PC & PC_MASK;
   // J replaces at most the low 28 bits of the PC; narrower PCs keep fewer.
   localparam int unsigned     LOW_W      = (XLEN < 28) ? XLEN : 28;

   state_t          state_r;
   logic [XLEN-1:0] pc_r;
   logic [XLEN-1:0] tgt_r;
   logic            imem_req_r;
   logic [XLEN-1:0] skid_pc_r;
   logic [31:0]     skid_instr_r;
   logic            o_valid_r;
   logic [XLEN-1:0] o_pc_r;
   logic [XLEN-1:0] o_pc4_r;
   logic [31:0]     o_instr_r;

   logic [27:0]     j_low_s;
   logic [XLEN-1:0] j_tgt_s;
   logic            j_kill_s;
   logic [XLEN-1:0] cur_pc_s;
   logic [XLEN-1:0] kill_tgt_s;
   logic            kill_s;
   logic            pending_s;
   logic            if_free_s;
   logic [XLEN-1:0] pc_nxt_s;
   logic [XLEN-1:0] imm_s;

   // Local J: a valid J in IF/ID acts as a redirect to the pseudo-direct target
   always_comb begin
      j_low_s                = {o_instr_r[25:0], 2'b00};
      j_tgt_s                = o_pc4_r;
      j_tgt_s[LOW_W-1:0]     = j_low_s[LOW_W-1:0];
      if ((J_LOCAL == 1'b1) && o_valid_r && (o_instr_r[31:26] == OP_J)) begin
         j_kill_s = 1'b1;
      end else begin
         j_kill_s = 1'b0;
      end
   end

   // Kill arbitration: redirect beats flush beats local J; flush keeps the PC
   // that would be fetched next (the latched target while a drop is pending)
   always_comb begin
      if (state_r == ST_DROP) begin
         cur_pc_s = tgt_r;
      end else begin
         cur_pc_s = pc_r;
      end
      if (i_redirect) begin
         kill_tgt_s = i_redirect_pc & PC_MASK;
      end else if (i_flush) begin
         kill_tgt_s = cur_pc_s;
      end else begin
         kill_tgt_s = j_tgt_s;
      end
      kill_s    = i_redirect | i_flush | j_kill_s;
      pending_s = imem_req_r & ~imem.imem_ack;
      if_free_s = ~o_valid_r | ~i_stall;
      pc_nxt_s  = pc_r + PC_INC;
   end

   // PC, fetch FSM, skid buffer and IF/ID register
   always_ff @(posedge Clk) begin
      if (!Rst) begin
         state_r      <= ST_BOOT;
         pc_r         <= RESET_PC_A;
         tgt_r        <= {XLEN{1'b0}};
         imem_req_r   <= 1'b0;
         skid_pc_r    <= {XLEN{1'b0}};
         skid_instr_r <= 32'h0;
         o_valid_r    <= 1'b0;
         o_pc_r       <= {XLEN{1'b0}};
         o_pc4_r      <= PC_INC;
         o_instr_r    <= 32'h0;
      end else if (kill_s) begin
         o_valid_r    <= 1'b0;
         o_instr_r    <= 32'h0;
         skid_pc_r    <= {XLEN{1'b0}};
         skid_instr_r <= 32'h0;
         imem_req_r   <= 1'b1;
         if (pending_s) begin
            // the in-flight request must still complete; its data is thrown away
            state_r <= ST_DROP;
            tgt_r   <= kill_tgt_s;
         end else begin
            state_r <= ST_REQ;
            pc_r    <= kill_tgt_s;
         end
      end else begin
         case (state_r)
            ST_BOOT: begin
               state_r    <= ST_REQ;
               imem_req_r <= 1'b1;
            end
            ST_REQ: begin
               if (imem.imem_ack) begin
                  pc_r <= pc_nxt_s;
                  if (if_free_s) begin
                     o_valid_r <= 1'b1;
                     o_pc_r    <= pc_r;
                     o_pc4_r   <= pc_nxt_s;
                     o_instr_r <= imem.imem_rdata;
                  end else begin
                     skid_pc_r    <= pc_r;
                     skid_instr_r <= imem.imem_rdata;
                     state_r      <= ST_HOLD;
                     imem_req_r   <= 1'b0;
                  end
               end else if (!i_stall) begin
                  // downstream took the instruction and nothing new arrived
                  o_valid_r <= 1'b0;
                  o_instr_r <= 32'h0;
               end
            end
            ST_HOLD: begin
               if (!i_stall) begin
                  o_valid_r  <= 1'b1;
                  o_pc_r     <= skid_pc_r;
                  o_pc4_r    <= skid_pc_r + PC_INC;
                  o_instr_r  <= skid_instr_r;
                  state_r    <= ST_REQ;
                  imem_req_r <= 1'b1;
               end
            end
            ST_DROP: begin
               if (imem.imem_ack) begin
                  pc_r    <= tgt_r;
                  state_r <= ST_REQ;
               end
            end
            default: begin
               state_r    <= ST_BOOT;
               imem_req_r <= 1'b0;
               o_valid_r  <= 1'b0;
               o_instr_r  <= 32'h0;
            end
         endcase
      end
   end

   // Sign-extend the 16-bit immediate to the PC width
   always_comb begin
      imm_s       = {XLEN{o_instr_r[15]}};
      imm_s[15:0] = o_instr_r[15:0];
   end

   assign imem.imem_req  = imem_req_r;
   assign imem.imem_addr = pc_r;
   assign o_valid        = o_valid_r;
   assign o_pc           = o_pc_r;
   assign o_pc4          = o_pc4_r;
   assign o_instr        = o_instr_r;
   assign o_rs           = o_instr_r[25:21];
   assign o_rt           = o_instr_r[20:16];
   assign o_rd           = o_instr_r[15:11];
   assign o_imm          = imm_s;

`ifdef FETCH_STATS_EN
   logic [31:0] fetch_cnt_r;
   logic [31:0] stall_cnt_r;
   logic [31:0] drop_cnt_r;
   logic        acc_s;
   logic        drop_s;
   logic        stl_s;

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      if (v == 32'hFFFF_FFFF) begin
         return v;
      end else begin
         return v + 32'd1;
      end
   endfunction

   // Classify this cycle's events for the statistics counters
   always_comb begin
      acc_s  = imem_req_r & imem.imem_ack & ~kill_s & (state_r == ST_REQ);
      drop_s = imem_req_r & imem.imem_ack & (kill_s | (state_r == ST_DROP));
      stl_s  = o_valid_r & i_stall;
   end

   // Saturating fetch/stall/drop counters
   always_ff @(posedge Clk) begin
      if (!Rst) begin
         fetch_cnt_r <= 32'h0;
         stall_cnt_r <= 32'h0;
         drop_cnt_r  <= 32'h0;
      end else begin
         if (acc_s) begin
            fetch_cnt_r <= sat_inc(fetch_cnt_r);
         end
         if (stl_s) begin
            stall_cnt_r <= sat_inc(stall_cnt_r);
         end
         if (drop_s) begin
            drop_cnt_r <= sat_inc(drop_cnt_r);
         end
      end
   end

   assign o_fetch_cnt = fetch_cnt_r;
   assign o_stall_cnt = stall_cnt_r;
   assign o_drop_cnt  = drop_cnt_r;
`endif

endmodule
